stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Parametrised multi-cycle controller for stack-based control transfers: CALL, RET, RETI and hardware interrupt entry.
- Sits beside decode. When a sequence runs, it takes over the memory-stage stack strobes and stalls fetch.
- Generalises the fixed two-word PC push/pop to any PC/stack-word width ratio.
- Adds a configurable pipeline drain, pop read-latency tracking and full PC/flag reassembly.

Parameters:
- PC_W, 32, program counter width.
- WORD_W, 16, stack word width. PC_W must be an integer multiple of WORD_W. PC_WORDS = PC_W/WORD_W.
- FLAG_W, 4, flag register width. FLAG_W <= WORD_W.
- DRAIN_CYCLES, 4, number of cycles of NOP insertion before interrupt entry. Must be >= 1.
- POP_LATENCY, 2, cycles from a mem_pop strobe to valid mem_rdata. Must be >= 1.
- INT_VECTOR, 32'h0, interrupt handler address. Used only with INT_VECTOR_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  decode presents a sequenced op
- req_op  in  2  op code: 00 CALL, 01 RET, 10 RETI, 11 reserved (ignored)
- req_ready  out  1  high = request accepted this cycle
- int_req  in  1  interrupt pending, level-sensitive
- pc_in  in  PC_W  return PC, captured on acceptance
- flags_in  in  FLAG_W  flag register, captured on interrupt acceptance
- mem_rdata  in  WORD_W  pop data
- mem_push  out  1  stack push strobe
- mem_pop  out  1  stack pop strobe
- push_data  out  WORD_W  word to be pushed
- busy  out  1  sequence in progress
- stall_fetch  out  1  hold the PC
- clear_instruction  out  1  inject a NOP into decode
- pc_load  out  1  one-cycle pulse to load pc_out
- pc_out  out  PC_W  reassembled or vector PC
- flags_load  out  1  one-cycle pulse to restore flags_out
- flags_out  out  FLAG_W  restored flags
- int_ack  out  1  one-cycle pulse when interrupt entry completes

Behaviour:
- Reset: state = IDLE. All outputs 0. Word counter, pop pipeline and capture registers all cleared.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0, partial data discarded.
- req_ready = (state == IDLE) && !int_req.
  - A request is accepted when req_valid && req_ready.
  - In IDLE, int_req has priority over req_valid.
  - Reserved op is ignored; the FSM stays in IDLE.
- busy = (state != IDLE). stall_fetch = busy.
- States: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, POP_FLAGS, POP_PC, WAIT_POP, DONE.
- CALL: IDLE -> PUSH_PC.
  - PUSH_PC lasts PC_WORDS cycles, pushing most-significant word first.
  - Then -> IDLE. There is no pc_load; the jump is resolved in execute.
- INT: IDLE -> DRAIN.
  - On entry, pc_in and flags_in are captured.
  - DRAIN lasts DRAIN_CYCLES cycles with clear_instruction = 1.
  - Then PUSH_PC (PC_WORDS cycles, MSW first), then PUSH_FLAGS.
  - PUSH_FLAGS lasts 1 cycle and pushes flags zero-extended to WORD_W.
  - Then DONE: int_ack = 1 for 1 cycle, then IDLE.
- RET: IDLE -> POP_PC (PC_WORDS cycles of mem_pop) -> WAIT_POP -> DONE.
  - Words pop LSW first, because the stack is LIFO.
- RETI: IDLE -> POP_FLAGS (1 cycle of mem_pop) -> POP_PC -> WAIT_POP -> DONE.
- Pop tracking:
  - A POP_LATENCY-deep shift register tags each mem_pop.
  - When a tag emerges, mem_rdata is written into the next capture slot: flags first if RETI, then PC word 0 (LSW) upward.
- WAIT_POP: exits to DONE in the cycle after the last tag is captured.
- DONE for RET/RETI:
  - pc_load = 1 with pc_out = reassembled PC.
  - RETI only: flags_load = 1 with flags_out = mem_rdata[FLAG_W-1:0] of the flags pop.
- push_data is valid only while mem_push = 1 and is 0 otherwise. mem_push and mem_pop are never high together.
- int_req asserting while busy is not sampled until the FSM returns to IDLE.
- A back-to-back request in the cycle after DONE is accepted, which gives a 1-cycle IDLE gap.
- Latencies (cycles from acceptance to IDLE):
  - CALL: PC_WORDS.
  - INT: DRAIN_CYCLES + PC_WORDS + 2.
  - RET: PC_WORDS + POP_LATENCY + 1 (including DONE).

Optional Feature:
- Macro: STACK_SEQ_INT_VECTOR_EN.
- Defined: in the INT DONE cycle, pc_load = 1 with pc_out = INT_VECTOR[PC_W-1:0], alongside int_ack.
- Undefined: INT DONE asserts only int_ack; pc_load stays 0 for interrupts and the handler address is supplied externally.

Test Plan:
- CALL, pc_in = 32'h0001_2345 -> 2 push cycles with push_data 16'h0001 then 16'h2345; busy high for 2 cycles; no pc_load.
- RET, mem_rdata returns 16'h2345 then 16'h0001 with POP_LATENCY = 2 -> pc_load pulse with pc_out = 32'h0001_2345 after 5 cycles.
- int_req with pc_in = 32'h0000_0100, flags_in = 4'b1010 -> 4 clear_instruction cycles, pushes 16'h0000, 16'h0100, 16'h000A, then an int_ack pulse; with the macro defined, pc_out = INT_VECTOR.
- RETI, pops return 16'h0005, 16'h0200, 16'h0000 -> flags_out = 4'b0101 and pc_out = 32'h0000_0200, pulsed together.
- int_req and req_valid(CALL) in the same IDLE cycle -> req_ready = 0 and the interrupt sequence runs; CALL is accepted on the first IDLE cycle after int_ack once int_req is deasserted.
- reset driven low during DRAIN cycle 2 -> all outputs 0 immediately; after release, a CALL completes normally.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: request, PC-control and stack-memory signals
// of the stack sequencer; master is the pipeline side, slave the sequencer.
interface stack_sequencer_if #(
    parameter int PC_W   = 32,
    parameter int WORD_W = 16,
    parameter int FLAG_W = 4
);
    logic              req_valid;
    logic [1:0]        req_op;
    logic              req_ready;
    logic              int_req;
    logic [PC_W-1:0]   pc_in;
    logic [FLAG_W-1:0] flags_in;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_push;
    logic              mem_pop;
    logic [WORD_W-1:0] push_data;
    logic              busy;
    logic              stall_fetch;
    logic              clear_instruction;
    logic              pc_load;
    logic [PC_W-1:0]   pc_out;
    logic              flags_load;
    logic [FLAG_W-1:0] flags_out;
    logic              int_ack;

    modport master (
        output req_valid,
        output req_op,
        output int_req,
        output pc_in,
        output flags_in,
        output mem_rdata,
        input  req_ready,
        input  mem_push,
        input  mem_pop,
        input  push_data,
        input  busy,
        input  stall_fetch,
        input  clear_instruction,
        input  pc_load,
        input  pc_out,
        input  flags_load,
        input  flags_out,
        input  int_ack
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  int_req,
        input  pc_in,
        input  flags_in,
        input  mem_rdata,
        output req_ready,
        output mem_push,
        output mem_pop,
        output push_data,
        output busy,
        output stall_fetch,
        output clear_instruction,
        output pc_load,
        output pc_out,
        output flags_load,
        output flags_out,
        output int_ack
    );
endinterface

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle CALL/RET/RETI/interrupt stack controller.
// Define STACK_SEQ_INT_VECTOR_EN to load INT_VECTOR into the PC on interrupt entry.
module stack_sequencer #(
    parameter int              PC_W         = 32,
    parameter int              WORD_W       = 16,
    parameter int              FLAG_W       = 4,
    parameter int              DRAIN_CYCLES = 4,
    parameter int              POP_LATENCY  = 2,
    parameter logic [PC_W-1:0] INT_VECTOR   = '0
) (
    input logic              clk,
    input logic              reset,
    stack_sequencer_if.slave bus
);
    localparam int PC_WORDS = PC_W / WORD_W;
    localparam int CNT_W    = $clog2(DRAIN_CYCLES + PC_WORDS + 2);
    localparam int CAP_W    = $clog2(PC_WORDS + 2);

    localparam logic [1:0] OP_CALL = 2'b00;
    localparam logic [1:0] OP_RET  = 2'b01;
    localparam logic [1:0] OP_RETI = 2'b10;

`ifdef STACK_SEQ_INT_VECTOR_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_PC,
        PUSH_FLAGS,
        POP_FLAGS,
        POP_PC,
        WAIT_POP,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               live;
    logic               is_int;
    logic               is_reti;
    logic [PC_W-1:0]    pc_cap;
    logic [FLAG_W-1:0]  flags_cap;
    logic [CAP_W-1:0]   cap_cnt;
    logic [POP_LATENCY-1:0] pop_pipe;

    logic               push;
    logic               pop;
    logic [WORD_W-1:0]  wdata;
    logic               clear;
    logic               load_pc;
    logic [PC_W-1:0]    pc_val;
    logic               load_flags;
    logic [FLAG_W-1:0]  flags_val;
    logic               ack;

    logic               ready;
    logic               op_call;
    logic               op_ret;
    logic               op_reti;
    logic               pop_tag;
    logic               flags_slot;
    logic               last_tag;
    logic [PC_W-1:0]    pc_shift;
    logic [WORD_W-1:0]  flags_word;

    // ready only in IDLE with no interrupt pending; live masks it during reset
    assign ready   = live && (state == IDLE) && !bus.int_req;
    assign op_call = (bus.req_op == OP_CALL);
    assign op_ret  = (bus.req_op == OP_RET);
    assign op_reti = (bus.req_op == OP_RETI);

    // a tag leaving the pipe means mem_rdata holds the matching pop word
    assign pop_tag    = pop_pipe[POP_LATENCY-1];
    assign flags_slot = is_reti && (cap_cnt == '0);
    assign last_tag   = pop_tag && (cap_cnt == (is_reti ? CAP_W'(PC_WORDS)
                                                        : CAP_W'(PC_WORDS - 1)));

    // LSW arrives first, so each new word enters at the top and shifts down
    assign pc_shift   = (pc_cap >> WORD_W) |
                        (PC_W'(bus.mem_rdata) << (PC_W - WORD_W));
    assign flags_word = WORD_W'(flags_cap);

    assign bus.req_ready         = ready;
    assign bus.busy              = (state != IDLE);
    assign bus.stall_fetch       = (state != IDLE);
    assign bus.mem_push          = push;
    assign bus.mem_pop           = pop;
    assign bus.push_data         = wdata;
    assign bus.clear_instruction = clear;
    assign bus.pc_load           = load_pc;
    assign bus.pc_out            = pc_val;
    assign bus.flags_load        = load_flags;
    assign bus.flags_out         = flags_val;
    assign bus.int_ack           = ack;

    // sequencer FSM; strobes are registered for the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            live       <= 1'b0;
            is_int     <= 1'b0;
            is_reti    <= 1'b0;
            pc_cap     <= '0;
            flags_cap  <= '0;
            cap_cnt    <= '0;
            pop_pipe   <= '0;
            push       <= 1'b0;
            pop        <= 1'b0;
            wdata      <= '0;
            clear      <= 1'b0;
            load_pc    <= 1'b0;
            pc_val     <= '0;
            load_flags <= 1'b0;
            flags_val  <= '0;
            ack        <= 1'b0;
        end else begin
            live       <= 1'b1;
            push       <= 1'b0;
            pop        <= 1'b0;
            wdata      <= '0;
            clear      <= 1'b0;
            load_pc    <= 1'b0;
            pc_val     <= '0;
            load_flags <= 1'b0;
            flags_val  <= '0;
            ack        <= 1'b0;

            pop_pipe[0] <= pop;
            for (int i = 1; i < POP_LATENCY; i++) begin
                pop_pipe[i] <= pop_pipe[i-1];
            end

            if (pop_tag) begin
                if (flags_slot) begin
                    flags_cap <= bus.mem_rdata[FLAG_W-1:0];
                end else begin
                    pc_cap <= pc_shift;
                end
                cap_cnt <= cap_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (live && bus.int_req) begin
                        state     <= DRAIN;
                        is_int    <= 1'b1;
                        is_reti   <= 1'b0;
                        pc_cap    <= bus.pc_in;
                        flags_cap <= bus.flags_in;
                        clear     <= 1'b1;
                    end else if (bus.req_valid && ready) begin
                        unique case (1'b1)
                            op_call: begin
                                state   <= PUSH_PC;
                                is_int  <= 1'b0;
                                is_reti <= 1'b0;
                                push    <= 1'b1;
                                wdata   <= bus.pc_in[PC_W-1 -: WORD_W];
                                pc_cap  <= bus.pc_in << WORD_W;
                            end
                            op_ret: begin
                                state   <= POP_PC;
                                is_int  <= 1'b0;
                                is_reti <= 1'b0;
                                pop     <= 1'b1;
                                pc_cap  <= '0;
                                cap_cnt <= '0;
                            end
                            op_reti: begin
                                state     <= POP_FLAGS;
                                is_int    <= 1'b0;
                                is_reti   <= 1'b1;
                                pop       <= 1'b1;
                                pc_cap    <= '0;
                                flags_cap <= '0;
                                cap_cnt   <= '0;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end

                DRAIN: begin
                    if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state  <= PUSH_PC;
                        cnt    <= '0;
                        push   <= 1'b1;
                        wdata  <= pc_cap[PC_W-1 -: WORD_W];
                        pc_cap <= pc_cap << WORD_W;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        clear <= 1'b1;
                    end
                end

                PUSH_PC: begin
                    if (cnt == CNT_W'(PC_WORDS - 1)) begin
                        cnt <= '0;
                        if (is_int) begin
                            state <= PUSH_FLAGS;
                            push  <= 1'b1;
                            wdata <= flags_word;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        push   <= 1'b1;
                        wdata  <= pc_cap[PC_W-1 -: WORD_W];
                        pc_cap <= pc_cap << WORD_W;
                    end
                end

                PUSH_FLAGS: begin
                    state   <= DONE;
                    ack     <= 1'b1;
                    load_pc <= VEC_EN;
                    pc_val  <= VEC_EN ? INT_VECTOR : '0;
                end

                POP_FLAGS: begin
                    state <= POP_PC;
                    cnt   <= '0;
                    pop   <= 1'b1;
                end

                POP_PC: begin
                    if (cnt == CNT_W'(PC_WORDS - 1)) begin
                        state <= WAIT_POP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        pop <= 1'b1;
                    end
                end

                WAIT_POP: begin
                    if (last_tag) begin
                        state      <= DONE;
                        load_pc    <= 1'b1;
                        pc_val     <= pc_shift;
                        load_flags <= is_reti;
                        flags_val  <= is_reti ? flags_cap : '0;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed checks of CALL, RET, RETI, interrupt entry,
// interrupt priority, reserved op and mid-sequence reset.
module tb_stack_sequencer;
    localparam logic [31:0] VEC = 32'h0000_0800;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] pop_q[$];
    logic h1 = 1'b0;
    logic h2 = 1'b0;

    always #5 clk = ~clk;

    stack_sequencer_if #(.PC_W(32), .WORD_W(16), .FLAG_W(4)) bus ();

    stack_sequencer #(
        .PC_W(32),
        .WORD_W(16),
        .FLAG_W(4),
        .DRAIN_CYCLES(4),
        .POP_LATENCY(2),
        .INT_VECTOR(VEC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {busy, stall, clear, push, pop, pc_load, flags_load, int_ack}
    function automatic logic [7:0] ctl();
        return {bus.busy, bus.stall_fetch, bus.clear_instruction,
                bus.mem_push, bus.mem_pop, bus.pc_load,
                bus.flags_load, bus.int_ack};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stack memory: data for a pop seen in cycle t is driven in cycle t+2
    initial begin
        bus.mem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            if (h2 && pop_q.size() > 0) bus.mem_rdata = pop_q.pop_front();
            else bus.mem_rdata = 16'hDEAD;
            h2 = h1;
            h1 = bus.mem_pop;
        end
    end

    initial begin
        logic [7:0] ack_ctl;
        logic [31:0] ack_pc;
`ifdef STACK_SEQ_INT_VECTOR_EN
        ack_ctl = 8'b1100_0101;
        ack_pc  = VEC;
`else
        ack_ctl = 8'b1100_0001;
        ack_pc  = 32'h0;
`endif
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.int_req   = 1'b0;
        bus.pc_in     = '0;
        bus.flags_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ctl", ctl(), 8'h00);
        check("rst ready", bus.req_ready, 1'b0);
        check("rst pc_out", bus.pc_out, 32'h0);
        check("rst push_data", bus.push_data, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        // CALL
        bus.pc_in = 32'h0001_2345;
        bus.req_op = 2'b00;
        bus.req_valid = 1'b1;
        #1;
        check("call ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        bus.pc_in = 32'hFFFF_FFFF;
        check("call c1 ctl", ctl(), 8'b1101_0000);
        check("call c1 data", bus.push_data, 16'h0001);
        tick();
        check("call c2 ctl", ctl(), 8'b1101_0000);
        check("call c2 data", bus.push_data, 16'h2345);
        tick();
        check("call end ctl", ctl(), 8'h00);
        check("call end data", bus.push_data, 16'h0);
        tick();

        // RET
        pop_q = '{16'h2345, 16'h0001};
        bus.req_op = 2'b01;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("ret c1 ctl", ctl(), 8'b1100_1000);
        tick();
        check("ret c2 ctl", ctl(), 8'b1100_1000);
        tick();
        check("ret c3 ctl", ctl(), 8'b1100_0000);
        tick();
        check("ret c4 ctl", ctl(), 8'b1100_0000);
        tick();
        check("ret done ctl", ctl(), 8'b1100_0100);
        check("ret pc_out", bus.pc_out, 32'h0001_2345);
        tick();
        check("ret end ctl", ctl(), 8'h00);
        tick();

        // interrupt entry
        bus.int_req = 1'b1;
        bus.pc_in = 32'h0000_0100;
        bus.flags_in = 4'b1010;
        #1;
        check("int ready", bus.req_ready, 1'b0);
        tick();
        check("int c1 ctl", ctl(), 8'b1110_0000);
        tick();
        check("int c2 ctl", ctl(), 8'b1110_0000);
        bus.int_req = 1'b0;
        bus.pc_in = 32'hFFFF_FFFF;
        bus.flags_in = 4'hF;
        tick();
        tick();
        check("int c4 ctl", ctl(), 8'b1110_0000);
        tick();
        check("int c5 ctl", ctl(), 8'b1101_0000);
        check("int c5 data", bus.push_data, 16'h0000);
        tick();
        check("int c6 data", bus.push_data, 16'h0100);
        tick();
        check("int c7 ctl", ctl(), 8'b1101_0000);
        check("int c7 flags", bus.push_data, 16'h000A);
        tick();
        check("int ack ctl", ctl(), ack_ctl);
        check("int pc_out", bus.pc_out, ack_pc);
        tick();
        check("int end ctl", ctl(), 8'h00);
        tick();

        // RETI
        pop_q = '{16'h0005, 16'h0200, 16'h0000};
        bus.req_op = 2'b10;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("reti c1 ctl", ctl(), 8'b1100_1000);
        tick();
        tick();
        check("reti c3 ctl", ctl(), 8'b1100_1000);
        tick();
        check("reti c4 ctl", ctl(), 8'b1100_0000);
        tick();
        tick();
        check("reti done ctl", ctl(), 8'b1100_0110);
        check("reti pc_out", bus.pc_out, 32'h0000_0200);
        check("reti flags", bus.flags_out, 4'b0101);
        tick();
        check("reti end ctl", ctl(), 8'h00);
        tick();

        // interrupt wins over a simultaneous CALL
        bus.int_req = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op = 2'b00;
        bus.pc_in = 32'h00AB_CDEF;
        bus.flags_in = 4'h3;
        #1;
        check("prio ready", bus.req_ready, 1'b0);
        tick();
        check("prio c1 ctl", ctl(), 8'b1110_0000);
        bus.int_req = 1'b0;
        repeat (4) tick();
        check("prio c5 data", bus.push_data, 16'h00AB);
        repeat (2) tick();
        check("prio c7 flags", bus.push_data, 16'h0003);
        tick();
        check("prio ack", bus.int_ack, 1'b1);
        check("prio ack ready", bus.req_ready, 1'b0);
        tick();
        check("prio gap ctl", ctl(), 8'h00);
        check("prio gap ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        check("prio call ctl", ctl(), 8'b1101_0000);
        check("prio call data", bus.push_data, 16'h00AB);
        tick();
        check("prio call data2", bus.push_data, 16'hCDEF);
        tick();
        check("prio end ctl", ctl(), 8'h00);

        // reserved op is ignored
        bus.req_op = 2'b11;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("rsvd ctl", ctl(), 8'h00);
        tick();

        // reset during DRAIN cycle 2
        bus.int_req = 1'b1;
        bus.pc_in = 32'h1111_2222;
        tick();
        bus.int_req = 1'b0;
        tick();
        check("mrst pre ctl", ctl(), 8'b1110_0000);
        #2;
        reset = 1'b0;
        #1;
        check("mrst ctl", ctl(), 8'h00);
        check("mrst ready", bus.req_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        bus.pc_in = 32'hCAFE_F00D;
        bus.req_op = 2'b00;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("mrst call data", bus.push_data, 16'hCAFE);
        tick();
        check("mrst call data2", bus.push_data, 16'hF00D);
        tick();
        check("mrst end ctl", ctl(), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
